// File: rtl/async_arf_pkg.sv
// Shared definitions for asynchronous-dataflow fabric nodes: op codes, a clog2
// helper and the legal op/operand-count check.
package async_arf_pkg;

    typedef enum logic [3:0] {
        OP_PASS,
        OP_ADDI,
        OP_SUBI,
        OP_MULI,
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_AND,
        OP_OR,
        OP_XOR
    } op_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r = r + 1;
        return r;
    endfunction

    // Single-operand ops consume the immediate; the rest fold 2 or 3 operands.
    function automatic bit op_legal(input op_e op, input int n_in);
        case (op)
            OP_PASS, OP_ADDI, OP_SUBI, OP_MULI: return n_in == 1;
            default:                            return (n_in >= 2) && (n_in <= 3);
        endcase
    endfunction

endpackage

// File: rtl/async_op_alu.sv
// Combinational operator of a dataflow node; all results wrap at DATA_WIDTH bits.
module async_op_alu import async_arf_pkg::*; #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    INPUT_SIZE = 2,
    parameter op_e                   OP         = OP_ADD,
    parameter logic [DATA_WIDTH-1:0] IMMEDIATE  = '0
) (
    input  logic [DATA_WIDTH-1:0] opnd_i [INPUT_SIZE],
    output logic [DATA_WIDTH-1:0] result_o
);

    always_comb begin
        result_o = opnd_i[0];
        case (OP)
            OP_PASS: result_o = opnd_i[0];
            OP_ADDI: result_o = opnd_i[0] + IMMEDIATE;
            OP_SUBI: result_o = opnd_i[0] - IMMEDIATE;
            OP_MULI: result_o = opnd_i[0] * IMMEDIATE;
            OP_ADD:  for (int k = 1; k < INPUT_SIZE; k++) result_o = result_o + opnd_i[k];
            OP_SUB:  for (int k = 1; k < INPUT_SIZE; k++) result_o = result_o - opnd_i[k];
            OP_MUL:  for (int k = 1; k < INPUT_SIZE; k++) result_o = result_o * opnd_i[k];
            OP_AND:  for (int k = 1; k < INPUT_SIZE; k++) result_o = result_o & opnd_i[k];
            OP_OR:   for (int k = 1; k < INPUT_SIZE; k++) result_o = result_o | opnd_i[k];
            OP_XOR:  for (int k = 1; k < INPUT_SIZE; k++) result_o = result_o ^ opnd_i[k];
            default: result_o = opnd_i[0];
        endcase
    end

endmodule

// File: rtl/async_operator_buf.sv
// Dataflow node: pulls operands over req/ack, computes one result per operand set and
// buffers it for several consumers that each drain at their own pace via private read pointers.
module async_operator_buf import async_arf_pkg::*; #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    INPUT_SIZE  = 2,
    parameter int                    OUTPUT_SIZE = 1,
    parameter int                    DEPTH       = 4,
    parameter op_e                   OP          = OP_ADD,
    parameter logic [DATA_WIDTH-1:0] IMMEDIATE   = '0
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic [INPUT_SIZE-1:0]             req_l,
    input  logic [INPUT_SIZE-1:0]             ack_l,
    input  logic [DATA_WIDTH*INPUT_SIZE-1:0]  din,
    input  logic [OUTPUT_SIZE-1:0]            req_r,
    output logic [OUTPUT_SIZE-1:0]            ack_r,
    output logic [DATA_WIDTH*OUTPUT_SIZE-1:0] dout,
    output logic [clog2(DEPTH):0]             level
);

    localparam int         AW         = clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);

    if (!op_legal(OP, INPUT_SIZE) || OUTPUT_SIZE < 1 || OUTPUT_SIZE > 8 ||
        DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("async_operator_buf: illegal OP/INPUT_SIZE/OUTPUT_SIZE/DEPTH combination");
    end

    logic [INPUT_SIZE-1:0]  req_l_q, req_l_d, has_q, has_d;
    logic [DATA_WIDTH-1:0]  opnd_q [INPUT_SIZE];
    logic [DATA_WIDTH-1:0]  opnd_d [INPUT_SIZE];
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q [OUTPUT_SIZE];
    logic [AW:0]            rd_ptr_d [OUTPUT_SIZE];
    logic [OUTPUT_SIZE-1:0] ack_r_q, ack_r_d;
    logic [DATA_WIDTH-1:0]  dout_q [OUTPUT_SIZE];
    logic [DATA_WIDTH-1:0]  dout_d [OUTPUT_SIZE];
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]  result;
    logic [AW:0]            level_w;
    logic                   full, push;

    async_op_alu #(
        .DATA_WIDTH(DATA_WIDTH),
        .INPUT_SIZE(INPUT_SIZE),
        .OP        (OP),
        .IMMEDIATE (IMMEDIATE)
    ) u_alu (
        .opnd_i  (opnd_q),
        .result_o(result)
    );

    // Occupancy is set by the slowest consumer, i.e. the largest modular distance.
    always_comb begin
        level_w = '0;
        for (int j = 0; j < OUTPUT_SIZE; j++)
            if ((wr_ptr_q - rd_ptr_q[j]) > level_w) level_w = wr_ptr_q - rd_ptr_q[j];
    end

    assign full = (level_w == FULL_LEVEL);
    assign push = (&has_q) && !full;

    always_comb begin
        req_l_d = req_l_q;
        has_d   = has_q;
        opnd_d  = opnd_q;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            if (ack_l[i] && !has_q[i]) begin
                opnd_d[i]  = din[i*DATA_WIDTH +: DATA_WIDTH];
                has_d[i]   = 1'b1;
                req_l_d[i] = 1'b0;
            end else if (push) begin
                has_d[i] = 1'b0;
            end else if (!has_q[i] && !req_l_q[i] && !ack_l[i]) begin
                req_l_d[i] = 1'b1;
            end
        end
    end

    // Pops only read entries written before this edge, so a same-edge push never bypasses.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        ack_r_d  = '0;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        for (int j = 0; j < OUTPUT_SIZE; j++) begin
            if (req_r[j] && !ack_r_q[j] && (wr_ptr_q != rd_ptr_q[j])) begin
                ack_r_d[j]  = 1'b1;
                dout_d[j]   = mem_q[rd_ptr_q[j][AW-1:0]];
                rd_ptr_d[j] = rd_ptr_q[j] + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_l_q  <= '0;
            has_q    <= '0;
            wr_ptr_q <= '0;
            ack_r_q  <= '0;
            for (int i = 0; i < INPUT_SIZE; i++) opnd_q[i] <= '0;
            for (int j = 0; j < OUTPUT_SIZE; j++) begin
                rd_ptr_q[j] <= '0;
                dout_q[j]   <= '0;
            end
        end else begin
            req_l_q  <= req_l_d;
            has_q    <= has_d;
            opnd_q   <= opnd_d;
            wr_ptr_q <= wr_ptr_d;
            ack_r_q  <= ack_r_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q[AW-1:0]] <= result;
    end

    always_ff @(posedge clk) begin
        if (!rst) assert ((ack_l & has_q) == '0)
            else $error("async_operator_buf: producer ack while operand already held");
    end

    assign req_l = req_l_q;
    assign ack_r = ack_r_q;
    assign level = level_w;

    for (genvar j = 0; j < OUTPUT_SIZE; j++) begin : g_dout
        assign dout[j*DATA_WIDTH +: DATA_WIDTH] = dout_q[j];
    end

endmodule
